// File: rtl/ex_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : ex_unit_pkg
// Brief  : Shared execute-stage encodings: bus widths, aluop/alusel codes.
// Rev    : 1.0  initial release
// ============================================================================
package ex_unit_pkg;

    localparam int AluOpBus   = 8;
    localparam int AluSelBus  = 3;
    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic [RegBus-1:0] ZeroWord     = '0;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;

    typedef logic [AluOpBus-1:0]  aluop_t;
    typedef logic [AluSelBus-1:0] alusel_t;

    // Result classes
    localparam alusel_t EXE_RES_NOP   = 3'b000;
    localparam alusel_t EXE_RES_LOGIC = 3'b001;
    localparam alusel_t EXE_RES_SHIFT = 3'b010;
    localparam alusel_t EXE_RES_ARITH = 3'b011;
    localparam alusel_t EXE_RES_MUL   = 3'b100;
    localparam alusel_t EXE_RES_MULH  = 3'b101;

    // Operation codes
    localparam aluop_t EXE_NOP_OP  = 8'h00;
    localparam aluop_t EXE_AND_OP  = 8'h24;
    localparam aluop_t EXE_OR_OP   = 8'h25;
    localparam aluop_t EXE_XOR_OP  = 8'h26;
    localparam aluop_t EXE_LUI_OP  = 8'h0F;
    localparam aluop_t EXE_SLL_OP  = 8'h7C;
    localparam aluop_t EXE_SRL_OP  = 8'h02;
    localparam aluop_t EXE_SRA_OP  = 8'h03;
    localparam aluop_t EXE_ADD_OP  = 8'h20;
    localparam aluop_t EXE_SUB_OP  = 8'h22;
    localparam aluop_t EXE_SLT_OP  = 8'h2A;
    localparam aluop_t EXE_SLTU_OP = 8'h2B;
    localparam aluop_t EXE_MUL_OP  = 8'h18;
    localparam aluop_t EXE_MULH_OP = 8'h19;

    // Magnitude as unsigned; 32'h80000000 maps to 2^31, which fits.
    function automatic logic [RegBus-1:0] abs32(input logic [RegBus-1:0] v);
        return v[RegBus-1] ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_unit_mul_iter.sv
`default_nettype none
// ============================================================================
// Module : mul_iter
// Brief  : Iterative signed 32x32->64 multiplier, BITS_PER_CYCLE bits/iteration.
// Rev    : 1.0  initial release
// ============================================================================
module mul_iter
    import ex_unit_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_flush,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_product
);

    localparam int         N      = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] C_LAST = 6'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic        r_sign;
    logic [5:0]  r_cnt;
    logic [63:0] w_pp;

    always_comb begin
        w_pp = '0;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (r_mplier[j]) begin
                w_pp = w_pp + (r_mcand << j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_flush) begin
                        r_mcand  <= {32'd0, abs32(i_op1)};
                        r_mplier <= abs32(i_op2);
                        r_sign   <= i_op1[31] ^ i_op2[31];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc    <= r_acc + w_pp;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt + 6'd1;
                        if (r_cnt == C_LAST) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy    = (r_state == ST_BUSY);
    assign o_done    = (r_state == ST_DONE);
    assign o_product = r_sign ? -r_acc : r_acc;

endmodule
`default_nettype wire

// File: rtl/ex_unit.sv
`default_nettype none
// ============================================================================
// Module : ex_unit
// Brief  : RV32IM execute stage: single-cycle ALU plus iterative multiplier.
// Rev    : 1.0  initial release
// ============================================================================
module ex_unit
    import ex_unit_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [AluSelBus-1:0]  alusel_i,
    input  logic [RegBus-1:0]     reg1_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  stallreq_o
);

    logic        w_mul_req;
    logic        w_start;
    logic        w_busy;
    logic        w_done;
    logic [63:0] w_product;
    logic [31:0] w_alu;
    logic        r_mulh;

    assign w_mul_req = (alusel_i == EXE_RES_MUL) || (alusel_i == EXE_RES_MULH);
    assign w_start   = w_mul_req && !flush_i && !w_busy && !w_done;

    mul_iter #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mul_iter (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_start),
        .i_flush   (flush_i),
        .i_op1     (reg1_i),
        .i_op2     (reg2_i),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_product (w_product)
    );

    // High/low word select is captured at start so it tracks the launched op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mulh <= 1'b0;
        end else if (w_start) begin
            r_mulh <= (alusel_i == EXE_RES_MULH);
        end
    end

    always_comb begin
        w_alu = ZeroWord;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  w_alu = reg1_i | reg2_i;
                    EXE_AND_OP: w_alu = reg1_i & reg2_i;
                    EXE_XOR_OP: w_alu = reg1_i ^ reg2_i;
                    EXE_LUI_OP: w_alu = reg1_i;
                    default:    w_alu = ZeroWord;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: w_alu = reg1_i << reg2_i[4:0];
                    EXE_SRL_OP: w_alu = reg1_i >> reg2_i[4:0];
                    EXE_SRA_OP: w_alu = $signed(reg1_i) >>> reg2_i[4:0];
                    default:    w_alu = ZeroWord;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADD_OP:  w_alu = reg1_i + reg2_i;
                    EXE_SUB_OP:  w_alu = reg1_i - reg2_i;
                    EXE_SLT_OP:  w_alu = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
                    EXE_SLTU_OP: w_alu = {31'd0, reg1_i < reg2_i};
                    default:     w_alu = ZeroWord;
                endcase
            end
            default: w_alu = ZeroWord;
        endcase
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = ZeroWord;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o   = '0;
            wreg_o = WriteDisable;
        end else if (w_busy) begin
            wreg_o     = WriteDisable;
            stallreq_o = !flush_i;
        end else if (w_done) begin
            wdata_o = r_mulh ? w_product[63:32] : w_product[31:0];
            wreg_o  = flush_i ? WriteDisable : wreg_i;
        end else if (w_mul_req) begin
            wreg_o     = WriteDisable;
            stallreq_o = !flush_i;
        end else begin
            wdata_o = w_alu;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_ex_unit
// Brief  : Self-checking bench for ex_unit at BITS_PER_CYCLE = 1 and 4.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ex_unit;
    import ex_unit_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       flush;
    logic [1:0][7:0]  aluop;
    logic [1:0][2:0]  alusel;
    logic [1:0][31:0] reg1;
    logic [1:0][31:0] reg2;
    logic [1:0][4:0]  wd_in;
    logic [1:0]       wreg_in;
    logic [1:0][4:0]  wd_out;
    logic [1:0]       wreg_out;
    logic [1:0][31:0] wdata;
    logic [1:0]       stall;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_unit #(.BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush_i(flush[0]), .aluop_i(aluop[0]), .alusel_i(alusel[0]),
        .reg1_i(reg1[0]), .reg2_i(reg2[0]), .wd_i(wd_in[0]), .wreg_i(wreg_in[0]),
        .wd_o(wd_out[0]), .wreg_o(wreg_out[0]), .wdata_o(wdata[0]), .stallreq_o(stall[0])
    );

    ex_unit #(.BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .flush_i(flush[1]), .aluop_i(aluop[1]), .alusel_i(alusel[1]),
        .reg1_i(reg1[1]), .reg2_i(reg2[1]), .wd_i(wd_in[1]), .wreg_i(wreg_in[1]),
        .wd_o(wd_out[1]), .wreg_o(wreg_out[1]), .wdata_o(wdata[1]), .stallreq_o(stall[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic we);
        alusel[d] = sel; aluop[d] = op; reg1[d] = a; reg2[d] = b;
        wd_in[d] = wd; wreg_in[d] = we;
    endtask

    task automatic idle(input int d);
        drive(d, EXE_RES_NOP, EXE_NOP_OP, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    // Reference: results straight from the instruction semantics.
    function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        if (sel == EXE_RES_LOGIC && op == EXE_OR_OP)   return a | b;
        if (sel == EXE_RES_LOGIC && op == EXE_AND_OP)  return a & b;
        if (sel == EXE_RES_LOGIC && op == EXE_XOR_OP)  return a ^ b;
        if (sel == EXE_RES_LOGIC && op == EXE_LUI_OP)  return a;
        if (sel == EXE_RES_SHIFT && op == EXE_SLL_OP)  return 32'(longint'(a) * (64'd1 << b[4:0]));
        if (sel == EXE_RES_SHIFT && op == EXE_SRL_OP)  return a / (32'd1 << b[4:0]);
        if (sel == EXE_RES_SHIFT && op == EXE_SRA_OP)  return 32'(sa >>> b[4:0]);
        if (sel == EXE_RES_ARITH && op == EXE_ADD_OP)  return 32'(longint'(a) + longint'(b));
        if (sel == EXE_RES_ARITH && op == EXE_SUB_OP)  return 32'(longint'(a) - longint'(b));
        if (sel == EXE_RES_ARITH && op == EXE_SLT_OP)  return (sa < sb) ? 32'd1 : 32'd0;
        if (sel == EXE_RES_ARITH && op == EXE_SLTU_OP) return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    // Apply one ALU op to both DUTs and check the same-cycle result.
    task automatic alu_step(input string tag, input logic [2:0] sel, input logic [7:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wd, input logic we);
        logic [31:0] exp;
        exp = ref_alu(sel, op, a, b);
        drive(0, sel, op, a, b, wd, we);
        drive(1, sel, op, a, b, wd, we);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_wdata"}, wdata[d], exp);
            chk({tag, "_wd"}, {27'd0, wd_out[d]}, {27'd0, wd});
            chk({tag, "_wreg"}, {31'd0, wreg_out[d]}, {31'd0, we});
            chk({tag, "_stall"}, {31'd0, stall[d]}, 32'd0);
        end
        @(posedge clk); #1;
    endtask

    // Launch one multiply on DUT d, measure its stall window, check the result.
    task automatic run_mul(input string tag, input int d, input logic high,
                           input logic [31:0] a, input logic [31:0] b);
        longint      pa, pb;
        logic [63:0] prod;
        logic [4:0]  wd;
        int          stalls;
        logic        wreg_leak;
        pa = longint'($signed(a)); pb = longint'($signed(b));
        prod = 64'(pa * pb);
        wd = 5'($urandom_range(1, 31));
        stalls = 0; wreg_leak = 1'b0;
        drive(d, high ? EXE_RES_MULH : EXE_RES_MUL, high ? EXE_MULH_OP : EXE_MUL_OP, a, b, wd, 1'b1);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall[d]) break;
            stalls++;
            if (wreg_out[d]) wreg_leak = 1'b1;
            @(posedge clk); #1;
        end
        chk({tag, "_stalls"}, 32'(stalls), 32'(32 / (d == 0 ? 1 : 4) + 1));
        chk({tag, "_wreg_during_stall"}, {31'd0, wreg_leak}, 32'd0);
        chk({tag, "_wdata"}, wdata[d], high ? prod[63:32] : prod[31:0]);
        chk({tag, "_wreg"}, {31'd0, wreg_out[d]}, 32'd1);
        chk({tag, "_wd"}, {27'd0, wd_out[d]}, {27'd0, wd});
        @(posedge clk); #1;
        idle(d);
    endtask

    initial begin
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a, b;

        rst = 1'b1; flush = 2'b00;
        drive(0, EXE_RES_ARITH, EXE_ADD_OP, 32'h1234, 32'h1, 5'd7, 1'b1);
        drive(1, EXE_RES_MUL, EXE_MUL_OP, 32'd5, 32'd6, 5'd9, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_wdata", wdata[d], 32'd0);
            chk("reset_wd", {27'd0, wd_out[d]}, 32'd0);
            chk("reset_wreg", {31'd0, wreg_out[d]}, 32'd0);
            chk("reset_stall", {31'd0, stall[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; idle(0); idle(1);

        alu_step("add_ovf", EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1);
        chk("add_ovf_const", ref_alu(EXE_RES_ARITH, EXE_ADD_OP, 32'h7FFFFFFF, 32'd1), 32'h80000000);
        alu_step("sra", EXE_RES_SHIFT, EXE_SRA_OP, 32'hF0000000, 32'd4, 5'd3, 1'b1);
        alu_step("sltu", EXE_RES_ARITH, EXE_SLTU_OP, 32'd1, 32'hFFFFFFFF, 5'd4, 1'b0);
        alu_step("slt", EXE_RES_ARITH, EXE_SLT_OP, 32'hFFFFFFFF, 32'd1, 5'd6, 1'b1);
        alu_step("lui", EXE_RES_LOGIC, EXE_LUI_OP, 32'hABCDE000, 32'h0, 5'd8, 1'b1);
        alu_step("nop", EXE_RES_NOP, EXE_ADD_OP, 32'h5, 32'h6, 5'd2, 1'b1);
        alu_step("unknown", EXE_RES_ARITH, 8'hFF, 32'h5, 32'h6, 5'd2, 1'b1);

        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    sel = EXE_RES_LOGIC;
                    case ($urandom_range(0, 3))
                        0: op = EXE_OR_OP; 1: op = EXE_AND_OP; 2: op = EXE_XOR_OP; default: op = EXE_LUI_OP;
                    endcase
                end
                1: begin
                    sel = EXE_RES_SHIFT;
                    case ($urandom_range(0, 2))
                        0: op = EXE_SLL_OP; 1: op = EXE_SRL_OP; default: op = EXE_SRA_OP;
                    endcase
                end
                2: begin
                    sel = EXE_RES_ARITH;
                    case ($urandom_range(0, 3))
                        0: op = EXE_ADD_OP; 1: op = EXE_SUB_OP; 2: op = EXE_SLT_OP; default: op = EXE_SLTU_OP;
                    endcase
                end
                default: begin
                    sel = EXE_RES_NOP; op = 8'($urandom);
                end
            endcase
            alu_step("rand_alu", sel, op, a, b, 5'($urandom), 1'($urandom));
        end

        run_mul("mul_m3x7", 0, 1'b0, 32'hFFFFFFFD, 32'd7);
        chk("mul_m3x7_const", 32'(longint'(-3) * 7), 32'hFFFFFFEB);
        run_mul("mulh_min", 0, 1'b1, 32'h80000000, 32'h80000000);
        run_mul("mulh_m1x1", 0, 1'b1, 32'hFFFFFFFF, 32'd1);
        run_mul("mul_zero", 0, 1'b0, 32'd0, 32'h12345678);

        // Flush in BUSY: no write-back, stall released, next op unaffected.
        drive(0, EXE_RES_MUL, EXE_MUL_OP, 32'd9, 32'd9, 5'd10, 1'b1);
        @(negedge clk);
        chk("flush_idle_stall", {31'd0, stall[0]}, 32'd1);
        repeat (10) begin @(posedge clk); #1; end
        flush[0] = 1'b1;
        @(negedge clk);
        chk("flush_busy_stall", {31'd0, stall[0]}, 32'd0);
        chk("flush_busy_wreg", {31'd0, wreg_out[0]}, 32'd0);
        @(posedge clk); #1;
        flush[0] = 1'b0;
        drive(0, EXE_RES_ARITH, EXE_ADD_OP, 32'd3, 32'd4, 5'd11, 1'b1);
        @(negedge clk);
        chk("post_flush_stall", {31'd0, stall[0]}, 32'd0);
        chk("post_flush_wdata", wdata[0], 32'd7);
        chk("post_flush_wreg", {31'd0, wreg_out[0]}, 32'd1);
        @(posedge clk); #1;

        // Flush in IDLE with a multiply present must not start it.
        flush[0] = 1'b1;
        drive(0, EXE_RES_MUL, EXE_MUL_OP, 32'd9, 32'd9, 5'd10, 1'b1);
        @(negedge clk);
        chk("flush_idle_nostall", {31'd0, stall[0]}, 32'd0);
        chk("flush_idle_wreg", {31'd0, wreg_out[0]}, 32'd0);
        @(posedge clk); #1;
        flush[0] = 1'b0;
        drive(0, EXE_RES_ARITH, EXE_SUB_OP, 32'd3, 32'd4, 5'd12, 1'b1);
        @(negedge clk);
        chk("flush_idle_next_wdata", wdata[0], 32'hFFFFFFFF);
        chk("flush_idle_next_wreg", {31'd0, wreg_out[0]}, 32'd1);
        @(posedge clk); #1;
        idle(0);

        run_mul("b2b_6x7", 1, 1'b0, 32'd6, 32'd7);
        chk("b2b_const", 32'(6 * 7), 32'd42);
        run_mul("b2b_2x3", 1, 1'b0, 32'd2, 32'd3);

        for (int i = 0; i < 6; i++) begin
            a = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom;
            b = $urandom;
            run_mul("rand_mul4", 1, 1'($urandom), a, b);
        end
        for (int i = 0; i < 2; i++) begin
            run_mul("rand_mul1", 0, 1'($urandom), $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
